id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 19-bit, 8-register CPU. It captures decoded controls and operands at the end of ID.
- Source operands are chosen by the forwarding selects mux_in1/mux_in2: 00 selects the regfile, 01 the MEM result, 10 the WB result.
- It contains the hazard FSM that covers what forwarding cannot:
  - the producer sitting in EX needs one bubble;
  - a load sitting in EX needs two bubbles.
- It drives the stall signal that holds IF/ID.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/fwd_mux.sv | 26 ++
 rtl/id_ex_stage.sv | 139 +++++++++++++
 tb/tb_id_ex_stage.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 19-bit, 8-register CPU pipeline.
//   DW/RW/OPW   : datapath, register-address and ALU-opcode widths
//   FWD_*       : forwarding mux select encodings
//   state_e     : ID/EX hazard FSM states
//   ex_pipe_t   : payload held in the ID/EX pipeline register
package cpu_pkg;

    localparam int unsigned DW  = 19;
    localparam int unsigned RW  = 3;
    localparam int unsigned OPW = 4;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        RUN     = 1'b0,
        LD_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic           valid;
        logic [RW-1:0]  rd;
        logic           regwrite;
        logic           memread;
        logic           memwrite;
        logic [OPW-1:0] alu_op;
        logic [DW-1:0]  op_a;
        logic [DW-1:0]  op_b;
        logic [DW-1:0]  imm;
    } ex_pipe_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: picks regfile, MEM or WB data by select code.
//   sel      : 2-bit forwarding select (11 behaves as regfile)
//   rf_data  : regfile read data
//   mem_data : MEM-stage result
//   wb_data  : WB-stage result
//   data_c   : selected operand (combinational)
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [1:0]    sel,
    input  logic [DW-1:0] rf_data,
    input  logic [DW-1:0] mem_data,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] data_c
);

    always_comb begin
        data_c = rf_data;
        case (sel)
            FWD_MEM: data_c = mem_data;
            FWD_WB:  data_c = wb_data;
            default: data_c = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load/ALU hazard FSM and stall counter.
//   Inputs : decoded ID instruction (id_*), regfile data, forwarding selects
//            and data, flush (taken branch kills ID).
//   Outputs: stall (combinational, holds PC and IF/ID), registered EX
//            instruction (ex_*), saturating stall_count.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [RW-1:0]   id_rs,
    input  logic [RW-1:0]   id_rt,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic [RW-1:0]   id_rd,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic [OPW-1:0]  id_alu_op,
    input  logic [DW-1:0]   id_imm,
    input  logic [DW-1:0]   rf_data1,
    input  logic [DW-1:0]   rf_data2,
    input  logic [1:0]      mux_in1,
    input  logic [1:0]      mux_in2,
    input  logic [DW-1:0]   mem_fwd_data,
    input  logic [DW-1:0]   wb_fwd_data,
    input  logic            flush,
    output logic            stall,
    output logic            ex_valid,
    output logic [RW-1:0]   ex_rd,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic [OPW-1:0]  ex_alu_op,
    output logic [DW-1:0]   ex_op_a,
    output logic [DW-1:0]   ex_op_b,
    output logic [DW-1:0]   ex_imm,
    output logic [CNTW-1:0] stall_count
);

    state_e          state_q, state_d;
    ex_pipe_t        ex_q, ex_d;
    logic [CNTW-1:0] stall_count_q, stall_count_d;
    logic [DW-1:0]   op_a_c, op_b_c;
    logic            haz_c;
    logic            stall_c;

    fwd_mux u_fwd_a (
        .sel      (mux_in1),
        .rf_data  (rf_data1),
        .mem_data (mem_fwd_data),
        .wb_data  (wb_fwd_data),
        .data_c   (op_a_c)
    );

    fwd_mux u_fwd_b (
        .sel      (mux_in2),
        .rf_data  (rf_data2),
        .mem_data (mem_fwd_data),
        .wb_data  (wb_fwd_data),
        .data_c   (op_b_c)
    );

    // Producer in EX whose result is not yet forwardable to the ID reader.
    assign haz_c = id_valid & ex_q.valid & ex_q.regwrite &
                   ((id_uses_rs & (ex_q.rd == id_rs)) |
                    (id_uses_rt & (ex_q.rd == id_rt)));

    // Next state, EX payload and stall; bubble (all zero) is the default capture.
    always_comb begin
        state_d       = state_q;
        ex_d          = '0;
        stall_c       = 1'b0;
        stall_count_d = stall_count_q;

        if (flush) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (haz_c) begin
                        stall_c = 1'b1;
                        // A load needs a second bubble until its data reaches WB.
                        state_d = ex_q.memread ? LD_WAIT : RUN;
                    end else begin
                        ex_d.valid    = id_valid;
                        ex_d.rd       = id_rd;
                        ex_d.regwrite = id_regwrite;
                        ex_d.memread  = id_memread;
                        ex_d.memwrite = id_memwrite;
                        ex_d.alu_op   = id_alu_op;
                        ex_d.op_a     = op_a_c;
                        ex_d.op_b     = op_b_c;
                        ex_d.imm      = id_imm;
                    end
                end
                LD_WAIT: begin
                    stall_c = 1'b1;
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        if (stall_c && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            ex_q          <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ex_q          <= ex_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall       = stall_c;
    assign ex_valid    = ex_q.valid;
    assign ex_rd       = ex_q.rd;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_alu_op   = ex_q.alu_op;
    assign ex_op_a     = ex_q.op_a;
    assign ex_op_b     = ex_q.op_b;
    assign ex_imm      = ex_q.imm;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic against a bubble-count reference model. A second instance with a
// 4-bit counter exercises saturation within a short run.
module tb_id_ex_stage;

    localparam int unsigned DW  = 19;
    localparam int unsigned RW  = 3;
    localparam int unsigned OPW = 4;

    logic           clk, rst_n;
    logic           id_valid, id_uses_rs, id_uses_rt;
    logic [RW-1:0]  id_rs, id_rt, id_rd;
    logic           id_regwrite, id_memread, id_memwrite;
    logic [OPW-1:0] id_alu_op;
    logic [DW-1:0]  id_imm, rf_data1, rf_data2, mem_fwd_data, wb_fwd_data;
    logic [1:0]     mux_in1, mux_in2;
    logic           flush;

    logic           stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite;
    logic [RW-1:0]  ex_rd;
    logic [OPW-1:0] ex_alu_op;
    logic [DW-1:0]  ex_op_a, ex_op_b, ex_imm;
    logic [15:0]    stall_count;

    logic           s_stall, s_valid, s_regwrite, s_memread, s_memwrite;
    logic [RW-1:0]  s_rd;
    logic [OPW-1:0] s_alu_op;
    logic [DW-1:0]  s_op_a, s_op_b, s_imm;
    logic [3:0]     s_count;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_alu_op(id_alu_op), .id_imm(id_imm), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .mux_in1(mux_in1), .mux_in2(mux_in2), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_data(wb_fwd_data), .flush(flush), .stall(stall), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_alu_op(ex_alu_op), .ex_op_a(ex_op_a),
        .ex_op_b(ex_op_b), .ex_imm(ex_imm), .stall_count(stall_count)
    );

    id_ex_stage #(.CNTW(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_alu_op(id_alu_op), .id_imm(id_imm), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .mux_in1(mux_in1), .mux_in2(mux_in2), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_data(wb_fwd_data), .flush(flush), .stall(s_stall), .ex_valid(s_valid),
        .ex_rd(s_rd), .ex_regwrite(s_regwrite), .ex_memread(s_memread),
        .ex_memwrite(s_memwrite), .ex_alu_op(s_alu_op), .ex_op_a(s_op_a),
        .ex_op_b(s_op_b), .ex_imm(s_imm), .stall_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: EX contents plus number of forced bubbles still owed.
    logic           exp_valid, exp_regwrite, exp_memread, exp_memwrite, exp_stall;
    logic [RW-1:0]  exp_rd;
    logic [OPW-1:0] exp_alu_op;
    logic [DW-1:0]  exp_op_a, exp_op_b, exp_imm;
    int             exp_count, exp_pending;

    logic           n_valid, n_regwrite, n_memread, n_memwrite;
    logic [RW-1:0]  n_rd;
    logic [OPW-1:0] n_alu_op;
    logic [DW-1:0]  n_op_a, n_op_b, n_imm;
    int             n_count, n_pending;

    function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] rf,
                                           input logic [DW-1:0] m, input logic [DW-1:0] w);
        if (sel == 2'd1) return m;
        if (sel == 2'd2) return w;
        return rf;
    endfunction

    task automatic model_reset();
        exp_valid = 0; exp_regwrite = 0; exp_memread = 0; exp_memwrite = 0;
        exp_rd = '0; exp_alu_op = '0; exp_op_a = '0; exp_op_b = '0; exp_imm = '0;
        exp_count = 0; exp_pending = 0; exp_stall = 0;
    endtask

    task automatic model_eval();
        logic hz;
        hz = id_valid && exp_valid && exp_regwrite &&
             ((id_uses_rs && exp_rd == id_rs) || (id_uses_rt && exp_rd == id_rt));
        n_valid = 0; n_regwrite = 0; n_memread = 0; n_memwrite = 0;
        n_rd = '0; n_alu_op = '0; n_op_a = '0; n_op_b = '0; n_imm = '0;
        n_pending = 0;
        exp_stall = 0;
        if (!rst_n || flush) begin
            exp_stall = 0;
        end else if (exp_pending > 0) begin
            exp_stall = 1;
            n_pending = exp_pending - 1;
        end else if (hz) begin
            exp_stall = 1;
            n_pending = exp_memread ? 1 : 0;
        end else begin
            n_valid = id_valid; n_rd = id_rd; n_regwrite = id_regwrite;
            n_memread = id_memread; n_memwrite = id_memwrite; n_alu_op = id_alu_op;
            n_op_a = pick(mux_in1, rf_data1, mem_fwd_data, wb_fwd_data);
            n_op_b = pick(mux_in2, rf_data2, mem_fwd_data, wb_fwd_data);
            n_imm = id_imm;
        end
        n_count = (exp_stall && exp_count < 65535) ? exp_count + 1 : exp_count;
    endtask

    // Advance one clock with the model in lockstep; returns #1 after the edge.
    task automatic tick();
        model_eval();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            exp_valid = n_valid; exp_rd = n_rd; exp_regwrite = n_regwrite;
            exp_memread = n_memread; exp_memwrite = n_memwrite; exp_alu_op = n_alu_op;
            exp_op_a = n_op_a; exp_op_b = n_op_b; exp_imm = n_imm;
            exp_count = n_count; exp_pending = n_pending;
        end
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0; id_rd = '0;
        id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_alu_op = '0; id_imm = '0;
        rf_data1 = '0; rf_data2 = '0; mux_in1 = '0; mux_in2 = '0;
        mem_fwd_data = '0; wb_fwd_data = '0; flush = 0;
    endtask

    // Instruction with no source reads: never hazards, becomes the EX producer.
    task automatic set_producer(input logic [RW-1:0] rd, input logic ld);
        id_valid = 1; id_uses_rs = 0; id_uses_rt = 0; id_rd = rd;
        id_regwrite = 1; id_memread = ld; id_memwrite = 0;
        id_alu_op = 4'($urandom); id_imm = 19'($urandom);
        rf_data1 = 19'($urandom); rf_data2 = 19'($urandom);
        mux_in1 = 2'b00; mux_in2 = 2'b00;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        #2;
        n_vec++;
        if ({ex_valid, ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_alu_op, ex_op_a, ex_op_b, ex_imm} !== '0) begin
            n_err++; $display("FAIL reset_ex_fields got valid=%b rd=%0d op_a=%h want all zero", ex_valid, ex_rd, ex_op_a);
        end
        n_vec++;
        if (stall_count !== 16'd0 || stall !== 1'b0) begin
            n_err++; $display("FAIL reset_count_stall got cnt=%0d stall=%b want 0/0", stall_count, stall);
        end
        tick();
        tick();
        #2 rst_n = 1;
        #1;
    endtask

    task automatic test_passthrough();
        idle_inputs();
        id_valid = 1; id_rs = 3'd1; id_rt = 3'd2; id_uses_rs = 1; id_uses_rt = 1;
        mux_in1 = 2'b00; rf_data1 = 19'h00123; rf_data2 = 19'($urandom);
        id_regwrite = 1; id_rd = 3'd3; id_alu_op = 4'd9; id_imm = 19'h1F0F0;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL pass_stall got %b want 0", stall); end
        tick();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_op_a !== 19'h00123 || ex_rd !== 3'd3 || ex_op_b !== exp_op_b) begin
            n_err++; $display("FAIL pass_capture got v=%b a=%h rd=%0d b=%h want 1/00123/3/%h", ex_valid, ex_op_a, ex_rd, ex_op_b, exp_op_b);
        end
        n_vec++;
        if (ex_alu_op !== 4'd9 || ex_imm !== 19'h1F0F0 || ex_regwrite !== 1'b1) begin
            n_err++; $display("FAIL pass_ctrl got op=%0d imm=%h rw=%b want 9/1f0f0/1", ex_alu_op, ex_imm, ex_regwrite);
        end
    endtask

    task automatic test_alu_hazard();
        set_producer(3'd4, 1'b0);
        tick();
        idle_inputs();
        id_valid = 1; id_rs = 3'd4; id_uses_rs = 1; id_rd = 3'd6; id_regwrite = 1;
        rf_data1 = 19'h00055;
        #1;
        n_vec++;
        if (stall !== 1'b1) begin n_err++; $display("FAIL alu_stall1 got %b want 1", stall); end
        tick();
        n_vec++;
        if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0) begin
            n_err++; $display("FAIL alu_bubble got v=%b rw=%b want 0/0", ex_valid, ex_regwrite);
        end
        mux_in1 = 2'b01; mem_fwd_data = 19'h7FFFF;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall2 got %b want 0", stall); end
        tick();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_op_a !== 19'h7FFFF || stall_count !== 16'd1) begin
            n_err++; $display("FAIL alu_fwd got v=%b a=%h cnt=%0d want 1/7ffff/1", ex_valid, ex_op_a, stall_count);
        end
    endtask

    task automatic test_load_use();
        set_producer(3'd5, 1'b1);
        tick();
        idle_inputs();
        id_valid = 1; id_rt = 3'd5; id_uses_rt = 1; id_rd = 3'd7; id_regwrite = 1;
        #1;
        n_vec++;
        if (stall !== 1'b1) begin n_err++; $display("FAIL ld_stall1 got %b want 1", stall); end
        tick();
        n_vec++;
        if (stall !== 1'b1 || ex_valid !== 1'b0) begin
            n_err++; $display("FAIL ld_stall2 got stall=%b v=%b want 1/0", stall, ex_valid);
        end
        tick();
        mux_in2 = 2'b10; wb_fwd_data = 19'h0ABCD;
        #1;
        n_vec++;
        if (stall !== 1'b0 || ex_valid !== 1'b0) begin
            n_err++; $display("FAIL ld_release got stall=%b v=%b want 0/0", stall, ex_valid);
        end
        tick();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_op_b !== 19'h0ABCD || stall_count !== 16'd3) begin
            n_err++; $display("FAIL ld_fwd got v=%b b=%h cnt=%0d want 1/0abcd/3", ex_valid, ex_op_b, stall_count);
        end
    endtask

    task automatic test_flush_ld_wait();
        set_producer(3'd5, 1'b1);
        tick();
        idle_inputs();
        id_valid = 1; id_rs = 3'd5; id_uses_rs = 1; id_rd = 3'd2; id_regwrite = 1;
        tick();
        flush = 1;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL flush_stall got %b want 0", stall); end
        tick();
        n_vec++;
        if (ex_valid !== 1'b0 || stall_count !== 16'd4) begin
            n_err++; $display("FAIL flush_bubble got v=%b cnt=%0d want 0/4", ex_valid, stall_count);
        end
        flush = 0;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL flush_run got stall=%b want 0", stall); end
        tick();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_rd !== 3'd2) begin
            n_err++; $display("FAIL flush_next got v=%b rd=%0d want 1/2", ex_valid, ex_rd);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_producer(3'd5, 1'b1);
        tick();
        idle_inputs();
        id_valid = 1; id_rt = 3'd5; id_uses_rt = 1; id_rd = 3'd1; id_regwrite = 1;
        tick();
        rst_n = 0;
        #1;
        n_vec++;
        if ({ex_valid, ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_alu_op, ex_op_a, ex_op_b, ex_imm} !== '0
            || stall_count !== 16'd0 || stall !== 1'b0) begin
            n_err++; $display("FAIL rst_mid got v=%b rd=%0d cnt=%0d stall=%b want zeros", ex_valid, ex_rd, stall_count, stall);
        end
        tick();
        #2 rst_n = 1;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL rst_mid_run got stall=%b want 0", stall); end
        tick();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_rd !== 3'd1) begin
            n_err++; $display("FAIL rst_mid_capture got v=%b rd=%0d want 1/1", ex_valid, ex_rd);
        end
    endtask

    task automatic test_sel11();
        idle_inputs();
        id_valid = 1; id_rd = 3'd6;
        mux_in1 = 2'b11; mux_in2 = 2'b11;
        rf_data1 = 19'h12345; rf_data2 = 19'h54321;
        mem_fwd_data = 19'h11111; wb_fwd_data = 19'h22222;
        tick();
        n_vec++;
        if (ex_op_a !== 19'h12345 || ex_op_b !== 19'h54321) begin
            n_err++; $display("FAIL sel11 got a=%h b=%h want 12345/54321", ex_op_a, ex_op_b);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 10; i++) begin
            set_producer(3'd0, 1'b1);
            tick();
            idle_inputs();
            id_valid = 1; id_rs = 3'd0; id_uses_rs = 1;
            tick();
            tick();
            n_vec++;
            if (stall_count !== 16'(exp_count) || s_count !== 4'((exp_count > 15) ? 15 : exp_count)) begin
                n_err++; $display("FAIL sat_%0d got cnt=%0d sat=%0d want %0d/%0d", i, stall_count, s_count,
                                  exp_count, (exp_count > 15) ? 15 : exp_count);
            end
        end
        n_vec++;
        if (s_count !== 4'hF || stall_count !== 16'd20) begin
            n_err++; $display("FAIL sat_final got sat=%h cnt=%0d want f/20", s_count, stall_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs = 3'($urandom_range(0, 3)); id_rt = 3'($urandom_range(0, 3));
            id_rd = 3'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
            id_regwrite = ($urandom_range(0, 3) != 0);
            id_memread = ($urandom_range(0, 2) == 0); id_memwrite = 1'($urandom);
            id_alu_op = 4'($urandom); id_imm = 19'($urandom);
            rf_data1 = 19'($urandom); rf_data2 = 19'($urandom);
            mem_fwd_data = 19'($urandom); wb_fwd_data = 19'($urandom);
            mux_in1 = 2'($urandom); mux_in2 = 2'($urandom);
            flush = ($urandom_range(0, 9) == 0);
            #1;
            model_eval();
            n_vec++;
            if (stall !== exp_stall || s_stall !== exp_stall) begin
                n_err++; $display("FAIL rnd_stall[%0d] got %b/%b want %b", i, stall, s_stall, exp_stall);
            end
            tick();
            n_vec++;
            if (ex_valid !== exp_valid || ex_rd !== exp_rd || ex_regwrite !== exp_regwrite ||
                ex_memread !== exp_memread || ex_memwrite !== exp_memwrite || ex_alu_op !== exp_alu_op) begin
                n_err++; $display("FAIL rnd_ctrl[%0d] got v%b rd%0d rw%b mr%b mw%b op%0d want v%b rd%0d rw%b mr%b mw%b op%0d",
                    i, ex_valid, ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_alu_op,
                    exp_valid, exp_rd, exp_regwrite, exp_memread, exp_memwrite, exp_alu_op);
            end
            n_vec++;
            if (ex_op_a !== exp_op_a || ex_op_b !== exp_op_b || ex_imm !== exp_imm) begin
                n_err++; $display("FAIL rnd_data[%0d] got a=%h b=%h imm=%h want a=%h b=%h imm=%h",
                    i, ex_op_a, ex_op_b, ex_imm, exp_op_a, exp_op_b, exp_imm);
            end
            n_vec++;
            if (stall_count !== 16'(exp_count) || s_count !== 4'((exp_count > 15) ? 15 : exp_count)) begin
                n_err++; $display("FAIL rnd_count[%0d] got %0d/%0d want %0d", i, stall_count, s_count, exp_count);
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        model_reset();
        test_reset();
        test_passthrough();
        test_alu_hazard();
        test_load_use();
        test_flush_ld_wait();
        test_reset_mid_stall();
        test_sel11();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
